// File: rtl/scanner_pkg.sv
// Shared definitions for the mux channel scanner.
//   NUM_CH, CNT_W  : channel count and settle counter width
//   ST_*           : FSM state encodings used by mux_channel_scanner
package scanner_pkg;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Last channel index; the select counter only wraps after this one.
    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

endpackage

// File: rtl/mux_channel_scanner_settle_timer.sv
// settle_timer: loadable down-counter that measures the settle time on each channel.
// Ports:
//   clk, reset  : clock and synchronous active-high reset (counter clears to 0)
//   load        : load load_value (takes priority over dec)
//   load_value  : value to load
//   dec         : decrement by one; saturates at zero
//   zero        : counter is zero
module settle_timer
    import scanner_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_value;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/mux_channel_scanner.sv
// mux_channel_scanner: steps a 4:1 mux select through channels 0..3, waits a
// programmable settle time on each, and captures the mux output into a
// per-channel snapshot bank. A one-cycle done pulse marks a complete scan.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : scan request, only honoured in IDLE
//   mux_y      : mux output being sampled
//   mux_sel    : registered select driven to the mux
//   busy       : high while settling/sampling
//   done       : one-cycle pulse after channel 3 is captured
//   snap       : snapshots, channel i at snap[i*DATA_W +: DATA_W]
//   changed    : per-channel change flags
// Build option: define SCAN_CHANGE_DETECT_EN to build the change-detect flags;
// otherwise changed is tied to zero.
module mux_channel_scanner
    import scanner_pkg::*;
#(
    parameter int DATA_W        = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_W-1:0]        mux_y,
    output logic [1:0]               mux_sel,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH*DATA_W-1:0] snap,
    output logic [NUM_CH-1:0]        changed
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]        state_reg, state_next;
    logic [1:0]        sel_reg;
    logic              busy_reg, done_reg;
    logic [DATA_W-1:0] snap_reg [NUM_CH];
    logic [NUM_CH-1:0] wr_en;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic              start_accept;

    assign start_accept = (state_reg == ST_IDLE) && start;

    settle_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (SETTLE_LOAD),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    always_comb begin
        state_next = state_reg;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                    tmr_load   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_next = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (sel_reg == LAST_CH) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETTLE;
                    tmr_load   = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they line up exactly
    // with the state they decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            sel_reg   <= 2'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == ST_SETTLE) || (state_next == ST_SAMPLE);
            done_reg  <= (state_next == ST_DONE);
            if (start_accept) begin
                sel_reg <= 2'd0;
            end else if ((state_reg == ST_SAMPLE) && (sel_reg != LAST_CH)) begin
                sel_reg <= sel_reg + 2'd1;
            end else if (state_reg == ST_DONE) begin
                sel_reg <= 2'd0;
            end
        end
    end

    // Per-channel capture strobe and output packing.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr_en[gi] = (state_reg == ST_SAMPLE) && (sel_reg == 2'(gi));
            assign snap[gi*DATA_W +: DATA_W] = snap_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                snap_reg[i] <= '0;
            end else if (wr_en[i]) begin
                snap_reg[i] <= mux_y;
            end
        end
    end

`ifdef SCAN_CHANGE_DETECT_EN
    logic [NUM_CH-1:0] changed_reg;

    // Compare against the snapshot value before this capture overwrites it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset || start_accept) begin
                changed_reg[i] <= 1'b0;
            end else if (wr_en[i]) begin
                changed_reg[i] <= (mux_y != snap_reg[i]);
            end
        end
    end

    assign changed = changed_reg;
`else
    assign changed = '0;
`endif

    assign mux_sel = sel_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Scoreboard bench for mux_channel_scanner: each issued scan pushes its expected
// snapshot/changed pair; a monitor pops and compares on every done pulse.
module tb_mux_channel_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mux_y;
    logic [1:0]  mux_sel;
    logic        busy, done;
    logic [15:0] snap;
    logic [3:0]  changed;
    logic [3:0]  d [4];

    typedef struct packed {
        logic [15:0] snap;
        logic [3:0]  changed;
    } exp_t;

    exp_t   exp_q [$];
    int     done_times [$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     n_done = 0;
    int     cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational 4:1 mux over fixed sources.
    assign mux_y = d[mux_sel];

    mux_channel_scanner dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mux_y   (mux_y),
        .mux_sel (mux_sel),
        .busy    (busy),
        .done    (done),
        .snap    (snap),
        .changed (changed)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Expected changed flags depend on the build.
    function automatic logic [3:0] chg(input logic [3:0] v);
`ifdef SCAN_CHANGE_DETECT_EN
        return v;
`else
        return 4'b0000 & v;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            n_done++;
            done_times.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending scan (cyc=%0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("scan_snap", {16'h0, snap}, {16'h0, e.snap});
                check("scan_changed", {28'h0, changed}, {28'h0, e.changed});
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);      // accepting edge (cycle 0 follows)
        #1 start = 1'b0;
    endtask

    initial begin
        int k, base_done;
        logic [1:0] esel;
        d[0] = 4'h3; d[1] = 4'hA; d[2] = 4'h5; d[3] = 4'hF;

        // 1. reset and idle
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mux_sel", {30'h0, mux_sel}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_snap", {16'h0, snap}, 32'h0);
        check("rst_changed", {28'h0, changed}, 32'h0);

        // 2. basic scan with per-cycle select/busy/done timing
        exp_q.push_back('{snap: 16'hF5A3, changed: chg(4'b1111)});
        pulse_start();
        for (k = 0; k <= 13; k++) begin
            @(negedge clk);
            esel = (k <= 12) ? ((k >= 9) ? 2'd3 : 2'(k / 3)) : 2'd0;
            check($sformatf("sel_c%0d", k), {30'h0, mux_sel}, {30'h0, esel});
            check($sformatf("busy_c%0d", k), {31'h0, busy}, {31'h0, (k <= 11)});
            check($sformatf("done_c%0d", k), {31'h0, done}, {31'h0, (k == 12)});
        end
        check("scan1_done_count", n_done, 1);

        // 3. start while busy and while in DONE is ignored
        exp_q.push_back('{snap: 16'hF5A3, changed: chg(4'b0000)});
        pulse_start();
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        check("ignore_done_count", n_done, 2);
        check("ignore_busy", {31'h0, busy}, 32'h0);

        // 4. reset mid-scan aborts and clears
        pulse_start();
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_mux_sel", {30'h0, mux_sel}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_snap", {16'h0, snap}, 32'h0);
        check("abort_changed", {28'h0, changed}, 32'h0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_done", n_done, 2);

        // 5. start held high: back-to-back scans with one IDLE cycle between
        base_done = done_times.size();
        exp_q.push_back('{snap: 16'hF5A3, changed: chg(4'b1111)});
        exp_q.push_back('{snap: 16'hF5A3, changed: chg(4'b0000)});
        exp_q.push_back('{snap: 16'hF5A3, changed: chg(4'b0000)});
        @(negedge clk);
        start = 1'b1;
        repeat (40) @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        check("held_done_count", n_done, 5);
        if (done_times.size() >= base_done + 3) begin
            check("held_gap1", done_times[base_done+1] - done_times[base_done], 14);
            check("held_gap2", done_times[base_done+2] - done_times[base_done+1], 14);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL held_gaps: got %0d done pulses expected 3", done_times.size() - base_done);
        end

        // 6. change channel 2 and rescan
        d[2] = 4'h6;
        exp_q.push_back('{snap: 16'hF6A3, changed: chg(4'b0100)});
        pulse_start();
        repeat (20) @(negedge clk);
        check("final_done_count", n_done, 6);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
